// File: rtl/codificador_pkg.sv
// Shared types and constants for the sequential 4-to-2 encoder.
package codificador_pkg;

  localparam int N_IN  = 4;
  localparam int W_OUT = 2;

  typedef enum logic [0:0] {IDLE, EMIT} state_t;

  typedef logic [W_OUT-1:0] code_t;
  typedef logic [N_IN-1:0]  vec_t;

  // True when exactly one bit of v is set.
  function automatic logic is_single(input vec_t v);
    return (v != '0) && ((v & (v - vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/codificador_4_2_seq_if.sv
// Request/code handshake bundle of the encoder; out_last exists only with CODIFICADOR_LAST_EN.
interface codificador_4_2_seq_if;
  import codificador_pkg::*;

  vec_t  A;
  logic  in_valid;
  logic  in_ready;
  code_t Y;
  logic  out_valid;
  logic  out_ready;
`ifdef CODIFICADOR_LAST_EN
  logic  out_last;

  modport master (
    output A, in_valid, out_ready,
    input  in_ready, Y, out_valid, out_last
  );

  modport slave (
    input  A, in_valid, out_ready,
    output in_ready, Y, out_valid, out_last
  );
`else
  modport master (
    output A, in_valid, out_ready,
    input  in_ready, Y, out_valid
  );

  modport slave (
    input  A, in_valid, out_ready,
    output in_ready, Y, out_valid
  );
`endif

endinterface

// File: rtl/codificador_prio_4_2.sv
// Combinational lowest-set-bit encoder; code is 00 when the vector is empty.
module codificador_prio_4_2
  import codificador_pkg::*;
(
  input  vec_t  vec,
  output code_t code,
  output logic  nonzero
);

  always_comb begin
    code    = 2'b00;
    nonzero = (vec != '0);
    casez (vec)
      4'b???1: code = 2'b00;
      4'b??10: code = 2'b01;
      4'b?100: code = 2'b10;
      4'b1000: code = 2'b11;
      default: code = 2'b00;
    endcase
  end

endmodule

// File: rtl/codificador_4_2_seq.sv
// Sequential 4-to-2 encoder: serialises every set bit of a request vector, lowest first.
// Optional out_last flag enabled by defining CODIFICADOR_LAST_EN.
module codificador_4_2_seq
  import codificador_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  codificador_4_2_seq_if.slave bus
);

  state_t state, next_state;
  vec_t   pend, pend_next;
  vec_t   clear_mask;
  code_t  code;
  logic   nonzero;
  logic   armed;
  logic   in_ready, out_valid;
  logic   in_fire, out_fire;

  codificador_prio_4_2 u_prio (
    .vec     (pend),
    .code    (code),
    .nonzero (nonzero)
  );

  // armed keeps in_ready low until the first edge after reset release.
  assign in_ready  = (state == IDLE) && armed;
  assign out_valid = (state == EMIT) && nonzero;
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = out_valid && bus.out_ready;

  always_comb begin
    next_state = state;
    pend_next  = pend;
    clear_mask = vec_t'(1) << code;
    case (state)
      IDLE: begin
        if (in_fire && (bus.A != '0)) begin
          pend_next  = bus.A;
          next_state = EMIT;
        end
      end
      EMIT: begin
        if (out_fire) begin
          pend_next = pend & ~clear_mask;
          if (pend_next == '0) next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        pend_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      armed <= 1'b0;
    end else begin
      state <= next_state;
      pend  <= pend_next;
      armed <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.Y         = code;
`ifdef CODIFICADOR_LAST_EN
  assign bus.out_last  = out_valid && is_single(pend);
`endif

  // Pending bits can only be retired, never added, while emitting.
  pend_shrinks: assert property (@(posedge clk) disable iff (!rst_n)
    (state == EMIT) |=> ((pend & ~$past(pend)) == '0));

endmodule

// File: tb/tb_codificador_4_2_seq.sv
// Directed self-checking bench for codificador_4_2_seq (out_last checks under CODIFICADOR_LAST_EN).
module tb_codificador_4_2_seq;
  import codificador_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  codificador_4_2_seq_if bus ();

  codificador_4_2_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.A = 4'b0000;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    tests++;
    if (bus.Y !== 2'b00) begin
      fails++; $display("FAIL reset_Y got=%b exp=00", bus.Y);
    end
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
    end
`ifdef CODIFICADOR_LAST_EN
    tests++;
    if (bus.out_last !== 1'b0) begin
      fails++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last);
    end
`endif
    rst_n = 1'b1;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL release_before_edge_in_ready got=%b exp=0", bus.in_ready);
    end
    step();
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_two_bits();
    bus.A = 4'b1010;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.Y !== 2'b01) begin
      fails++; $display("FAIL a1010_beat0 valid=%b Y=%b exp valid=1 Y=01", bus.out_valid, bus.Y);
    end
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL a1010_in_ready_emit got=%b exp=0", bus.in_ready);
    end
`ifdef CODIFICADOR_LAST_EN
    tests++;
    if (bus.out_last !== 1'b0) begin
      fails++; $display("FAIL a1010_last0 got=%b exp=0", bus.out_last);
    end
`endif
    step();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.Y !== 2'b11) begin
      fails++; $display("FAIL a1010_beat1 valid=%b Y=%b exp valid=1 Y=11", bus.out_valid, bus.Y);
    end
`ifdef CODIFICADOR_LAST_EN
    tests++;
    if (bus.out_last !== 1'b1) begin
      fails++; $display("FAIL a1010_last1 got=%b exp=1", bus.out_last);
    end
`endif
    step();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL a1010_done valid=%b in_ready=%b exp valid=0 in_ready=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_stall();
    logic  rdy_pat  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    code_t exp_y    [6] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
    logic  exp_last [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.A = 4'b1111;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = rdy_pat[i];
      tests++;
      if (bus.out_valid !== 1'b1 || bus.Y !== exp_y[i]) begin
        fails++; $display("FAIL stall_cycle%0d valid=%b Y=%b exp valid=1 Y=%b", i, bus.out_valid, bus.Y, exp_y[i]);
      end
`ifdef CODIFICADOR_LAST_EN
      tests++;
      if (bus.out_last !== exp_last[i]) begin
        fails++; $display("FAIL stall_last%0d got=%b exp=%b", i, bus.out_last, exp_last[i]);
      end
`else
      if (exp_last[i] === 1'bx) $display("unreachable");
`endif
      step();
    end
    bus.out_ready = 1'b1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL stall_done valid=%b in_ready=%b exp valid=0 in_ready=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_zero_vector();
    bus.A = 4'b0000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        fails++; $display("FAIL zero_cycle%0d valid=%b in_ready=%b exp valid=0 in_ready=1", i, bus.out_valid, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_ignore_during_emit();
    bus.A = 4'b0011;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.A = 4'b0100;
    tests++;
    if (bus.Y !== 2'b00 || bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL ignore_beat0 Y=%b in_ready=%b exp Y=00 in_ready=0", bus.Y, bus.in_ready);
    end
    step();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.Y !== 2'b01) begin
      fails++; $display("FAIL ignore_beat1 valid=%b Y=%b exp valid=1 Y=01", bus.out_valid, bus.Y);
    end
    step();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL ignore_bubble valid=%b in_ready=%b exp valid=0 in_ready=1", bus.out_valid, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.Y !== 2'b10) begin
      fails++; $display("FAIL ignore_captured valid=%b Y=%b exp valid=1 Y=10", bus.out_valid, bus.Y);
    end
    step();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL ignore_done valid=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_emit();
    bus.A = 4'b1011;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.Y !== 2'b00) begin
      fails++; $display("FAIL rstmid_beat0 valid=%b Y=%b exp valid=1 Y=00", bus.out_valid, bus.Y);
    end
    step();
    rst_n = 1'b0;
    step();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.Y !== 2'b00 || bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_cleared valid=%b Y=%b in_ready=%b exp 0 00 0", bus.out_valid, bus.Y, bus.in_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        fails++; $display("FAIL rstmid_stale%0d valid=%b in_ready=%b exp valid=0 in_ready=1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.A = 4'b0001;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.A = 4'b0110;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.Y !== 2'b00) begin
      fails++; $display("FAIL b2b_first valid=%b Y=%b exp valid=1 Y=00", bus.out_valid, bus.Y);
    end
`ifdef CODIFICADOR_LAST_EN
    tests++;
    if (bus.out_last !== 1'b1) begin
      fails++; $display("FAIL b2b_first_last got=%b exp=1", bus.out_last);
    end
`endif
    step();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_bubble valid=%b in_ready=%b exp valid=0 in_ready=1", bus.out_valid, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.Y !== 2'b01) begin
      fails++; $display("FAIL b2b_second0 valid=%b Y=%b exp valid=1 Y=01", bus.out_valid, bus.Y);
    end
    step();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.Y !== 2'b10) begin
      fails++; $display("FAIL b2b_second1 valid=%b Y=%b exp valid=1 Y=10", bus.out_valid, bus.Y);
    end
    step();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_done valid=%b exp=0", bus.out_valid);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_two_bits();
    test_stall();
    test_zero_vector();
    test_ignore_during_emit();
    test_reset_mid_emit();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
